booth_seq_ctrl: RTL and testbench

Sequential controller for a signed radix-2 Booth multiplier. It time-shares a single WIDTH+1-bit adder/subtractor, built from the team's full/half adder cells, across WIDTH iteration cycles instead of instantiating a full array. Operands enter through a valid/ready handshake, and the 2·WIDTH-bit signed product leaves through a second valid/ready handshake. It sits between the operand source and the product consumer in the multiplier datapath.

---
 rtl/booth_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_booth_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// Sequential signed radix-2 Booth multiplier controller: one shared WIDTH+1-bit adder/subtractor, one Booth step per cycle.
// Latency: out_valid rises WIDTH cycles after the accept edge (1..WIDTH with BOOTH_SEQ_EARLY_TERM_EN defined).
// Backpressure: in_ready only in IDLE; product/out_valid hold in DONE until out_ready, no overlap of operations.
module booth_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH:0]    a_q, a_d;      // extra bit absorbs A-M overflow for the most negative M
    logic [WIDTH:0]    m_q, m_d;      // sign-extended multiplicand
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q1_q, q1_d;
    logic [CW-1:0]     cnt_q, cnt_d;  // Booth steps still to perform

    // Booth recoding of the current bit pair {Q[0], Q_1}
    logic              op_add;
    logic              op_sub;
    logic [WIDTH:0]    add_b;
    logic [WIDTH:0]    add_sum;
    logic [WIDTH:0]    step_a;

    assign op_add = ~q_q[0] &  q1_q;   // pair 01
    assign op_sub =  q_q[0] & ~q1_q;   // pair 10
    assign add_b  = op_sub ? ~m_q : m_q;

    // Shared ripple adder of full-adder cells; subtraction is A + ~M + 1 via carry-in
    always_comb begin
        logic c;
        add_sum = '0;
        c       = op_sub;
        for (int i = 0; i <= WIDTH; i++) begin
            add_sum[i] = a_q[i] ^ add_b[i] ^ c;
            c          = (a_q[i] & add_b[i]) | (c & (a_q[i] ^ add_b[i]));
        end
    end

    assign step_a = (op_add | op_sub) ? add_sum : a_q;

`ifdef BOOTH_SEQ_EARLY_TERM_EN
    // Remaining multiplier bits Q[cnt-1:0] all matching Q_1 means every remaining
    // pair is 00 or 11, so the rest of the work is a pure arithmetic shift by cnt.
    logic [WIDTH-1:0]          rem_mask;
    logic                      et_hit;
    logic signed [2*WIDTH+1:0] et_vec;

    assign rem_mask = ~({WIDTH{1'b1}} << cnt_q);
    assign et_hit   = ((q_q ^ {WIDTH{q1_q}}) & rem_mask) == '0;
    assign et_vec   = $signed({a_q, q_q, q1_q}) >>> cnt_q;
`endif

    // State and datapath registers; reset clears everything and returns to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update: load on accept, one Booth step per CALC cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    q1_d    = 1'b0;
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    cnt_d   = CNT_INIT;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
`ifdef BOOTH_SEQ_EARLY_TERM_EN
                if (et_hit) begin
                    {a_d, q_d, q1_d} = et_vec;
                    cnt_d            = '0;
                    state_d          = S_DONE;
                end else begin
                    a_d   = {step_a[WIDTH], step_a[WIDTH:1]};
                    q_d   = {step_a[0], q_q[WIDTH-1:1]};
                    q1_d  = q_q[0];
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_DONE;
                    end
                end
`else
                a_d   = {step_a[WIDTH], step_a[WIDTH:1]};
                q_d   = {step_a[0], q_q[WIDTH-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs come straight from state and registers only
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = {a_q[WIDTH-1:0], q_q};

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Testbench for booth_seq_ctrl: directed and random operations against a plain-arithmetic reference.
// Latency: checks exact out_valid cycle count per operation.
// Backpressure: holds out_ready low and checks that product/out_valid stay stable.
module tb_booth_seq_ctrl;

    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [W-1:0]     mcand = '0;
    logic [W-1:0]     mplier = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [2*W-1:0]   product;

    int checks = 0;
    int errors = 0;

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference product: ordinary signed multiplication, truncated to 2W bits
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] q);
        int mi;
        int qi;
        int p;
        mi = int'($signed(m));
        qi = int'($signed(q));
        p  = mi * qi;
        return p[2*W-1:0];
    endfunction

    // Early-terminating latency: step k finishes the job if the multiplier bits
    // from k-1 upward, with an implicit 0 below bit 0, are all identical.
    function automatic int early_lat(input logic [W-1:0] q);
        logic [W:0] e;
        bit         same;
        int         lat;
        lat = W;
        e   = {q, 1'b0};
        for (int k = W; k >= 1; k--) begin
            same = 1'b1;
            for (int j = k - 1; j <= W; j++) begin
                if (e[j] != e[W]) same = 1'b0;
            end
            if (same) lat = k;
        end
        return lat;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] q);
`ifdef BOOTH_SEQ_EARLY_TERM_EN
        return early_lat(q);
`else
        return (q === q) ? W : W;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input int hold, input bit noise);
        int             lat;
        int             budget;
        logic [2*W-1:0] exp_p;
        exp_p  = ref_prod(m, q);
        budget = 0;
        while (!in_ready && budget < 20) begin
            step();
            budget++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        mcand    = m;
        mplier   = q;
        step();
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                mcand    = W'($urandom);
                mplier   = W'($urandom);
            end
            step();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat(q)));
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("product", 32'(product), 32'(exp_p));
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                mcand    = W'($urandom);
            end
            step();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_product", 32'(product), 32'(exp_p));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        step();

        // Directed products, including the most negative multiplicand
        run_op(4'd3, 4'hE, 0, 1'b0);
        run_op(4'h8, 4'h8, 0, 1'b0);
        run_op(4'd7, 4'd7, 0, 1'b0);
        run_op(4'h8, 4'd7, 0, 1'b0);
        run_op(4'd6, 4'd0, 0, 1'b0);
        run_op(4'd6, 4'hF, 0, 1'b0);
        run_op(4'd3, 4'd5, 0, 1'b0);

        // Backpressure: six cycles without out_ready
        run_op(4'd5, 4'd3, 6, 1'b0);

        // Asynchronous reset in the middle of CALC
        in_valid = 1'b1;
        mcand    = 4'd5;
        mplier   = 4'd3;
        step();
        in_valid = 1'b0;
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_product", 32'(product), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            step();
            chk("postrst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(4'd2, 4'd3, 0, 1'b0);

        // Operand/in_valid noise while busy
        run_op(4'hB, 4'h6, 2, 1'b1);

        // Exhaustive sweep
        for (int mi = 0; mi < 16; mi++) begin
            for (int qi = 0; qi < 16; qi++) begin
                run_op(W'(mi), W'(qi), 0, 1'b0);
            end
        end

        // Random operations with random backpressure and noise
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
